fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core; sits directly upstream of the instruction field splitter.
- Holds the PC, issues one request at a time to instruction memory and accepts a variable-latency response.
- Delivers the fetched word, PC+4 and a valid bit to decode.
- Honours hazard-unit stall, decode flush and branch/jump redirect.

---
 rtl/fetch_stage.sv | 157 +++++++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
//
// Keeps the PC and issues one instruction-memory request at a time. Each response
// (variable latency) goes into IF/ID together with PC+4 and a valid bit. The stage
// honours the hazard-unit stall, the decode flush and the branch/jump redirect.
//
// Ports:
//   clk, reset     - clock (rising edge); asynchronous active-high reset
//   imem_req       - one-cycle fetch request pulse
//   imem_addr      - fetch address (equals PC)
//   imem_rvalid    - memory response valid
//   imem_rdata     - fetched word, valid when imem_rvalid is high
//   stall          - hold IF/ID and PC
//   flush          - turn IF/ID into a bubble, no redirect
//   branch_taken   - redirect fetch to branch_target
//   branch_target  - redirect address (word aligned)
//   inst, pc_plus4 - IF/ID instruction and the PC+4 that goes with it
//   valid          - IF/ID holds a real instruction
module fetch_stage #(
    parameter int unsigned             INST_W   = 32,
    parameter int unsigned             ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              valid
);

    localparam logic [1:0] StIssue  = 2'd0;
    localparam logic [1:0] StWait   = 2'd1;
    localparam logic [1:0] StHold   = 2'd2;
    localparam logic [1:0] StSquash = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic [INST_W-1:0] buf_inst_q, buf_inst_d;
    logic [ADDR_W-1:0] buf_pc4_q, buf_pc4_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;

    logic              deliver;
    logic [INST_W-1:0] dlv_inst;
    logic [ADDR_W-1:0] dlv_pc4;

    assign imem_addr = pc_q;
    assign imem_req  = (state_q == StIssue) && !reset;
    assign inst      = inst_q;
    assign pc_plus4  = pc4_q;
    assign valid     = valid_q;

    // Wraps modulo 2^ADDR_W.
    assign pc_inc = pc_q + ADDR_W'(4);

    // Fetch FSM and PC
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_inst_d = buf_inst_q;
        buf_pc4_d  = buf_pc4_q;
        deliver    = 1'b0;
        dlv_inst   = imem_rdata;
        dlv_pc4    = pc_inc;

        if (branch_taken) begin
            pc_d = branch_target;
            case (state_q)
                StIssue:  state_d = StSquash;
                StWait:   state_d = imem_rvalid ? StIssue : StSquash;
                StHold:   state_d = StIssue;
                StSquash: state_d = imem_rvalid ? StIssue : StSquash;
            endcase
        end else begin
            case (state_q)
                StIssue: state_d = StWait;
                StWait: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            // Park the word so the PC does not run ahead of IF/ID.
                            buf_inst_d = imem_rdata;
                            buf_pc4_d  = pc_inc;
                            state_d    = StHold;
                        end else begin
                            deliver = 1'b1;
                            pc_d    = pc_inc;
                            state_d = StIssue;
                        end
                    end
                end
                StHold: begin
                    if (!stall) begin
                        deliver  = 1'b1;
                        dlv_inst = buf_inst_q;
                        dlv_pc4  = buf_pc4_q;
                        pc_d     = buf_pc4_q;
                        state_d  = StIssue;
                    end
                end
                StSquash: begin
                    // Stall is ignored here: the stale response is simply dropped.
                    if (imem_rvalid) state_d = StIssue;
                end
            endcase
        end
    end

    // IF/ID register: a kill (redirect or flush) beats stall, and stall beats delivery.
    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (branch_taken || flush) begin
            inst_d  = '0;
            valid_d = 1'b0;
        end else if (stall) begin
            inst_d  = inst_q;
        end else if (deliver) begin
            inst_d  = dlv_inst;
            pc4_d   = dlv_pc4;
            valid_d = 1'b1;
        end else begin
            inst_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIssue;
            pc_q       <= RESET_PC;
            buf_inst_q <= '0;
            buf_pc4_q  <= '0;
            inst_q     <= '0;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_inst_q <= buf_inst_d;
            buf_pc4_q  <= buf_pc4_d;
            inst_q     <= inst_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: per-cycle vector table for fetch_stage (RESET_PC = 0x100), plus a
// hand-written sequence for asynchronous reset while a request is outstanding.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] inst;
    logic [31:0] pc_plus4;
    logic        valid;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(
        .INST_W   (32),
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .inst          (inst),
        .pc_plus4      (pc_plus4),
        .valid         (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A response must never coincide with a new request.
    always @(posedge clk) begin
        if (!reset && imem_rvalid && imem_req) begin
            $display("FAIL protocol: imem_rvalid=1 while imem_req=1, required no overlap");
            n_fail++;
        end
    end

    typedef struct {
        logic        rv;
        logic [31:0] rdata;
        logic        st;
        logic        fl;
        logic        br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rv, input logic [31:0] rdata, input logic st,
                       input logic fl, input logic br, input logic [31:0] tgt,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic [31:0] e_inst, input logic [31:0] e_pc4,
                       input logic e_valid);
        vec_t v;
        v = '{rv, rdata, st, fl, br, tgt, e_req, e_addr, e_inst, e_pc4, e_valid};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Inputs are driven just after a rising edge; the request outputs are checked before
    // the next edge and the IF/ID outputs just after it.
    task automatic apply(input int idx, input vec_t v);
        string tag;
        tag           = $sformatf("cycle%0d", idx);
        imem_rvalid   = v.rv;
        imem_rdata    = v.rdata;
        stall         = v.st;
        flush         = v.fl;
        branch_taken  = v.br;
        branch_target = v.tgt;
        #1;
        check({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, v.e_req});
        check({tag, ".imem_addr"}, imem_addr, v.e_addr);
        @(posedge clk);
        #1;
        check({tag, ".inst"}, inst, v.e_inst);
        check({tag, ".pc_plus4"}, pc_plus4, v.e_pc4);
        check({tag, ".valid"}, {31'b0, valid}, {31'b0, v.e_valid});
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;

        //   rv rdata         st fl br tgt           req addr          inst          pc4           v
        // 1-cycle memory, two sequential fetches
        add(0, 32'h0,          0, 0, 0, 32'h0,        1, 32'h100,       32'h0,        32'h0,        0);
        add(1, 32'h2001_0005,  0, 0, 0, 32'h0,        0, 32'h100,       32'h2001_0005,32'h104,      1);
        add(0, 32'h0,          0, 0, 0, 32'h0,        1, 32'h104,       32'h0,        32'h104,      0);
        add(1, 32'h2002_0007,  0, 0, 0, 32'h0,        0, 32'h104,       32'h2002_0007,32'h108,      1);
        // stall in ISSUE holds a valid IF/ID; then latency 3 with stall across rvalid
        add(0, 32'h0,          1, 0, 0, 32'h0,        1, 32'h108,       32'h2002_0007,32'h108,      1);
        add(0, 32'h0,          0, 0, 0, 32'h0,        0, 32'h108,       32'h0,        32'h108,      0);
        add(0, 32'h0,          0, 0, 0, 32'h0,        0, 32'h108,       32'h0,        32'h108,      0);
        add(1, 32'hAAAA_0001,  1, 0, 0, 32'h0,        0, 32'h108,       32'h0,        32'h108,      0);
        add(0, 32'h0,          1, 0, 0, 32'h0,        0, 32'h108,       32'h0,        32'h108,      0);
        add(0, 32'h0,          0, 0, 0, 32'h0,        0, 32'h108,       32'hAAAA_0001,32'h10C,      1);
        add(0, 32'h0,          0, 0, 0, 32'h0,        1, 32'h10C,       32'h0,        32'h10C,      0);
        // branch in WAIT without rvalid, late response squashed
        add(0, 32'h0,          0, 0, 1, 32'h400,      0, 32'h10C,       32'h0,        32'h10C,      0);
        add(0, 32'h0,          0, 0, 0, 32'h0,        0, 32'h400,       32'h0,        32'h10C,      0);
        add(1, 32'hDEAD_BEEF,  0, 0, 0, 32'h0,        0, 32'h400,       32'h0,        32'h10C,      0);
        add(0, 32'h0,          0, 0, 0, 32'h0,        1, 32'h400,       32'h0,        32'h10C,      0);
        // branch coincident with rvalid: data dropped, immediate request to target
        add(1, 32'h1111_2222,  0, 0, 1, 32'h800,      0, 32'h400,       32'h0,        32'h10C,      0);
        add(0, 32'h0,          0, 0, 0, 32'h0,        1, 32'h800,       32'h0,        32'h10C,      0);
        add(1, 32'h3333_4444,  0, 0, 0, 32'h0,        0, 32'h800,       32'h3333_4444,32'h804,      1);
        // flush alone while valid: bubble, PC unchanged
        add(0, 32'h0,          0, 1, 0, 32'h0,        1, 32'h804,       32'h0,        32'h804,      0);
        add(0, 32'h0,          0, 0, 0, 32'h0,        0, 32'h804,       32'h0,        32'h804,      0);
        add(1, 32'h5555_6666,  0, 0, 0, 32'h0,        0, 32'h804,       32'h5555_6666,32'h808,      1);
        // flush with stall: flush kills IF/ID, FSM still honours stall
        add(0, 32'h0,          1, 1, 0, 32'h0,        1, 32'h808,       32'h0,        32'h808,      0);
        add(1, 32'h7777_8888,  1, 0, 0, 32'h0,        0, 32'h808,       32'h0,        32'h808,      0);
        add(0, 32'h0,          0, 0, 0, 32'h0,        0, 32'h808,       32'h7777_8888,32'h80C,      1);
        // branch in ISSUE to the top word, stale response squashed, then wrap to 0
        add(0, 32'h0,          0, 0, 1, 32'hFFFF_FFFC,1, 32'h80C,       32'h0,        32'h80C,      0);
        add(1, 32'h0BAD_F00D,  0, 0, 0, 32'h0,        0, 32'hFFFF_FFFC, 32'h0,        32'h80C,      0);
        add(0, 32'h0,          0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'h0,        32'h80C,      0);
        add(1, 32'h9999_AAAA,  0, 0, 0, 32'h0,        0, 32'hFFFF_FFFC, 32'h9999_AAAA,32'h0,        1);
        add(0, 32'h0,          0, 0, 0, 32'h0,        1, 32'h0,         32'h0,        32'h0,        0);
        // get a valid word into IF/ID, then stall in ISSUE so WAIT starts with valid=1
        add(1, 32'hCAFE_0001,  0, 0, 0, 32'h0,        0, 32'h0,         32'hCAFE_0001,32'h4,        1);
        add(0, 32'h0,          1, 0, 0, 32'h0,        1, 32'h4,         32'hCAFE_0001,32'h4,        1);

        // Reset state
        #2;
        check("reset.imem_req", {31'b0, imem_req}, 32'h0);
        check("reset.imem_addr", imem_addr, 32'h100);
        check("reset.inst", inst, 32'h0);
        check("reset.pc_plus4", pc_plus4, 32'h0);
        check("reset.valid", {31'b0, valid}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) apply(i, vecs[i]);

        // Async reset mid-WAIT with a response pending
        stall = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBEEF_0002;
        #2;
        reset = 1'b1;
        #1;
        check("areset.inst", inst, 32'h0);
        check("areset.pc_plus4", pc_plus4, 32'h0);
        check("areset.valid", {31'b0, valid}, 32'h0);
        check("areset.imem_req", {31'b0, imem_req}, 32'h0);
        check("areset.imem_addr", imem_addr, 32'h100);
        @(posedge clk);
        #1;
        check("areset_edge.imem_req", {31'b0, imem_req}, 32'h0);
        check("areset_edge.valid", {31'b0, valid}, 32'h0);
        imem_rvalid = 1'b0;
        reset = 1'b0;
        #1;
        check("post_reset.imem_req", {31'b0, imem_req}, 32'h1);
        check("post_reset.imem_addr", imem_addr, 32'h100);
        @(posedge clk);
        #1;
        v = '{1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0,
              1'b0, 32'h100, 32'h1234_5678, 32'h104, 1'b1};
        apply(999, v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
